pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_if.sv | 38 +++
 rtl/pipe_ctrl.sv | 135 +++++++++++++
 tb/tb_pipe_ctrl.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// rtl/pipe_ctrl_if.sv - stall/flush control bundle between pipeline stages and pipe_ctrl
//
// Signals:
//   stallreq_if/id/ex/mem  per-stage stall requests
//   exc_valid/exc_eret     exception (or eret) reported from MEM
//   exc_code/epc_i         exception cause and eret return address
//   perf_clr               clears the stall-cycle counter
//   stall[5:0]             per-stage hold (bit0 PC .. bit5 WB)
//   flush/new_pc           one-cycle flush pulse and redirect target
//   stall_cycles           count of cycles with stall[0]=1
// Modports: slave = pipe_ctrl side, master = pipeline/bench side.
interface pipe_ctrl_if;
    logic        stallreq_if;
    logic        stallreq_id;
    logic        stallreq_ex;
    logic        stallreq_mem;
    logic        exc_valid;
    logic        exc_eret;
    logic [4:0]  exc_code;
    logic [31:0] epc_i;
    logic        perf_clr;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic [31:0] stall_cycles;

    modport slave (
        input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
        input  exc_valid, exc_eret, exc_code, epc_i, perf_clr,
        output stall, flush, new_pc, stall_cycles
    );

    modport master (
        output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
        output exc_valid, exc_eret, exc_code, epc_i, perf_clr,
        input  stall, flush, new_pc, stall_cycles
    );
endinterface

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush controller with exception redirect
//
// Ports:
//   clk   clock, rising edge
//   rst   synchronous active-high reset
//   bus   pipe_ctrl_if.slave (stall requests and exception in; stall, flush,
//         new_pc and stall_cycles out)
// Parameters:
//   EXC_BASE     exception vector base; vector = EXC_BASE + code*4
//   HOLD_CYCLES  cycles after a flush during which exceptions are masked (1..15)
module pipe_ctrl #(
    parameter logic [31:0] EXC_BASE    = 32'h0000_0020,
    parameter int unsigned HOLD_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst,
    pipe_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        WAIT_MEM = 2'd1,
        FLUSH    = 2'd2,
        HOLD     = 2'd3
    } state_t;

    localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES);

    state_t      state_q, state_d;
    logic [3:0]  hold_cnt_q, hold_cnt_d;
    logic        cap_en;
    logic        cap_eret_q;
    logic [4:0]  cap_code_q;
    logic [31:0] cap_epc_q;
    logic        rst_q;
    logic [31:0] stall_cnt_q;
    logic [5:0]  req_stall;
    logic [5:0]  stall_o;
    logic        flush_o;
    logic [31:0] new_pc_o;

    // Deepest requesting stage wins; it and everything upstream holds.
    always_comb begin
        req_stall = 6'b000000;
        if (bus.stallreq_mem)     req_stall = 6'b011111;
        else if (bus.stallreq_ex) req_stall = 6'b001111;
        else if (bus.stallreq_id) req_stall = 6'b000111;
        else if (bus.stallreq_if) req_stall = 6'b000011;
    end

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        cap_en     = 1'b0;
        case (state_q)
            RUN: begin
                if (bus.exc_valid) begin
                    cap_en  = 1'b1;
                    state_d = bus.stallreq_mem ? WAIT_MEM : FLUSH;
                end
            end
            WAIT_MEM: begin
                if (!bus.stallreq_mem) state_d = FLUSH;
            end
            FLUSH: begin
                state_d    = HOLD;
                hold_cnt_d = HOLD_LOAD;
            end
            HOLD: begin
                if (hold_cnt_q <= 4'd1) begin
                    state_d    = RUN;
                    hold_cnt_d = 4'd0;
                end else begin
                    hold_cnt_d = hold_cnt_q - 4'd1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Outputs depend only on registered state and stall requests. rst_q
    // forces them quiet for the cycle after reset is sampled.
    always_comb begin
        stall_o  = 6'b000000;
        flush_o  = 1'b0;
        new_pc_o = 32'h0;
        if (!rst_q) begin
            case (state_q)
                RUN, HOLD: stall_o = req_stall;
                WAIT_MEM:  stall_o = 6'b011111;
                FLUSH: begin
                    flush_o  = 1'b1;
                    new_pc_o = cap_eret_q ? cap_epc_q
                                          : EXC_BASE + {25'b0, cap_code_q, 2'b00};
                end
                default: stall_o = 6'b000000;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            hold_cnt_q <= 4'd0;
            cap_eret_q <= 1'b0;
            cap_code_q <= 5'd0;
            cap_epc_q  <= 32'h0;
            rst_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            rst_q      <= 1'b0;
            if (cap_en) begin
                cap_eret_q <= bus.exc_eret;
                cap_code_q <= bus.exc_code;
                cap_epc_q  <= bus.epc_i;
            end
        end
    end

    // Saturating stall-cycle counter; perf_clr overrides the increment.
    always_ff @(posedge clk) begin
        if (rst || bus.perf_clr) begin
            stall_cnt_q <= 32'h0;
        end else if (stall_o[0] && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign bus.stall        = stall_o;
    assign bus.flush        = flush_o;
    assign bus.new_pc       = new_pc_o;
    assign bus.stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - self-checking bench for pipe_ctrl with reference model
module tb_pipe_ctrl;

    localparam logic [31:0] BASE = 32'h0000_0020;
    localparam int          HOLD = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_ctrl_if bus ();

    pipe_ctrl #(.EXC_BASE(BASE), .HOLD_CYCLES(HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: what the pipeline is currently doing.
    bit     m_quiet;      // cycle right after reset was sampled
    bit     m_waiting;    // exception accepted, waiting for MEM to drain
    bit     m_flushing;   // this cycle is the flush cycle
    int     m_masked;     // remaining cycles in which exceptions are ignored
    bit     m_eret;
    int     m_code;
    logic [31:0] m_epc;
    longint m_cnt;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    // req bits: 0 if, 1 id, 2 ex, 3 mem
    function automatic logic [5:0] depth_mask(input logic [3:0] req);
        int depth;
        depth = req[3] ? 5 : req[2] ? 4 : req[1] ? 3 : req[0] ? 2 : 0;
        return 6'((1 << depth) - 1);
    endfunction

    task automatic step(input logic r, input logic [3:0] req, input logic ev, input logic er,
                        input logic [4:0] code, input logic [31:0] epc, input logic pc);
        logic [5:0]  e_stall;
        logic        e_flush;
        logic [31:0] e_pc;
        @(negedge clk);
        rst              = r;
        bus.stallreq_if  = req[0];
        bus.stallreq_id  = req[1];
        bus.stallreq_ex  = req[2];
        bus.stallreq_mem = req[3];
        bus.exc_valid    = ev;
        bus.exc_eret     = er;
        bus.exc_code     = code;
        bus.epc_i        = epc;
        bus.perf_clr     = pc;
        #1;
        e_stall = 6'b0;
        e_flush = 1'b0;
        e_pc    = 32'h0;
        if (!m_quiet) begin
            if (m_flushing) begin
                e_flush = 1'b1;
                e_pc    = m_eret ? m_epc : 32'(BASE + 32'(m_code * 4));
            end else if (m_waiting) begin
                e_stall = 6'b011111;
            end else begin
                e_stall = depth_mask(req);
            end
        end
        check_val("stall", 32'(bus.stall), 32'(e_stall));
        check_val("flush", 32'(bus.flush), 32'(e_flush));
        check_val("new_pc", bus.new_pc, e_pc);
        check_val("stall_cycles", bus.stall_cycles, m_cnt[31:0]);
        // advance model to the next cycle
        if (r) begin
            m_quiet = 1; m_waiting = 0; m_flushing = 0; m_masked = 0;
            m_eret = 0; m_code = 0; m_epc = 32'h0; m_cnt = 0;
        end else begin
            m_quiet = 0;
            if (pc) m_cnt = 0;
            else if (e_stall[0] && m_cnt < 64'hFFFF_FFFF) m_cnt++;
            if (m_flushing) begin
                m_flushing = 0;
                m_masked   = HOLD;
            end else if (m_waiting) begin
                if (!req[3]) begin
                    m_waiting  = 0;
                    m_flushing = 1;
                end
            end else if (m_masked > 0) begin
                m_masked--;
            end else if (ev) begin
                m_eret = er; m_code = int'(code); m_epc = epc;
                if (req[3]) m_waiting = 1;
                else        m_flushing = 1;
            end
        end
    endtask

    task automatic idle();
        step(0, 4'h0, 0, 0, 5'd0, 32'h0, 0);
    endtask

    logic [31:0] c0;

    initial begin
        rst = 1'b1;
        bus.stallreq_if = 0; bus.stallreq_id = 0; bus.stallreq_ex = 0; bus.stallreq_mem = 0;
        bus.exc_valid = 0; bus.exc_eret = 0; bus.exc_code = 0; bus.epc_i = 0; bus.perf_clr = 0;
        repeat (2) @(posedge clk);
        m_quiet = 1; m_waiting = 0; m_flushing = 0; m_masked = 0;
        m_eret = 0; m_code = 0; m_epc = 32'h0; m_cnt = 0;

        // reset holds outputs quiet even with all requests up
        step(1, 4'hF, 0, 0, 5'd0, 32'h0, 0);
        check_val("rst_stall", 32'(bus.stall), 32'h0);
        step(0, 4'hF, 0, 0, 5'd0, 32'h0, 0);
        check_val("rst_cnt", bus.stall_cycles, 32'h0);
        idle();

        // id+ex together: EX wins, counter +1 per cycle
        step(0, 4'b0110, 0, 0, 5'd0, 32'h0, 0);
        check_val("idex_stall", 32'(bus.stall), 32'h0F);
        c0 = bus.stall_cycles;
        step(0, 4'b0110, 0, 0, 5'd0, 32'h0, 0);
        check_val("idex_cnt", bus.stall_cycles, c0 + 32'd1);
        step(0, 4'b0110, 0, 0, 5'd0, 32'h0, 0);
        check_val("idex_cnt2", bus.stall_cycles, c0 + 32'd2);

        // exception code 4, then retries during HOLD, then first RUN cycle
        step(0, 4'h0, 1, 0, 5'd4, 32'h0, 0);
        step(0, 4'h7, 0, 0, 5'd0, 32'h0, 0);
        check_val("exc_flush", 32'(bus.flush), 32'h1);
        check_val("exc_pc", bus.new_pc, 32'h0000_0030);
        check_val("exc_stall", 32'(bus.stall), 32'h0);
        step(0, 4'h0, 1, 0, 5'd4, 32'h0, 0);
        step(0, 4'h0, 1, 0, 5'd4, 32'h0, 0);
        check_val("hold_noflush", 32'(bus.flush), 32'h0);
        step(0, 4'h0, 1, 0, 5'd4, 32'h0, 0);
        check_val("hold_noflush2", 32'(bus.flush), 32'h0);
        idle();
        check_val("run_accept", 32'(bus.flush), 32'h1);
        idle(); idle();

        // eret redirect
        step(0, 4'h0, 1, 1, 5'd7, 32'h0000_1234, 0);
        idle();
        check_val("eret_pc", bus.new_pc, 32'h0000_1234);
        idle();
        check_val("eret_one", 32'(bus.flush), 32'h0);
        idle();

        // exception while MEM busy for three cycles
        step(0, 4'h8, 1, 0, 5'd1, 32'h0, 0);
        step(0, 4'h8, 0, 0, 5'd0, 32'h0, 0);
        check_val("wait_stall", 32'(bus.stall), 32'h1F);
        step(0, 4'h8, 1, 0, 5'd9, 32'h0, 0);
        step(0, 4'h0, 0, 0, 5'd0, 32'h0, 0);
        check_val("wait_stall2", 32'(bus.stall), 32'h1F);
        check_val("wait_noflush", 32'(bus.flush), 32'h0);
        idle();
        check_val("wait_flush", 32'(bus.flush), 32'h1);
        check_val("wait_pc", bus.new_pc, 32'h0000_0024);
        idle(); idle();

        // reset during WAIT_MEM and during HOLD abandons the exception
        step(0, 4'h8, 1, 0, 5'd2, 32'h0, 0);
        step(1, 4'h8, 0, 0, 5'd0, 32'h0, 0);
        idle();
        check_val("rstwait_nf", 32'(bus.flush), 32'h0);
        idle();
        check_val("rstwait_nf2", 32'(bus.flush), 32'h0);
        step(0, 4'h0, 1, 0, 5'd3, 32'h0, 0);
        idle();
        step(1, 4'h0, 0, 0, 5'd0, 32'h0, 0);
        idle(); idle();

        // counter saturation and clear
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt_q;
        m_cnt = 64'hFFFF_FFFE;
        step(0, 4'h2, 0, 0, 5'd0, 32'h0, 0);
        step(0, 4'h2, 0, 0, 5'd0, 32'h0, 0);
        check_val("sat_max", bus.stall_cycles, 32'hFFFF_FFFF);
        step(0, 4'h2, 0, 0, 5'd0, 32'h0, 0);
        check_val("sat_hold", bus.stall_cycles, 32'hFFFF_FFFF);
        step(0, 4'h2, 0, 0, 5'd0, 32'h0, 1);
        idle();
        check_val("clr", bus.stall_cycles, 32'h0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] rq;
            rq[0] = ($urandom_range(0, 3) == 0);
            rq[1] = ($urandom_range(0, 4) == 0);
            rq[2] = ($urandom_range(0, 5) == 0);
            rq[3] = ($urandom_range(0, 2) == 0);
            step(($urandom_range(0, 60) == 0), rq, ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 2) == 0), 5'($urandom), 32'($urandom),
                 ($urandom_range(0, 40) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
